accumulator_bank: RTL and testbench

- Parametrised successor to the 3-column accumulator: NUM_COLS columns, DEPTH rows per buffer, double-buffered, with a per-row read-out port and a single-cycle buffer clear.
- Sits between the systolic MMU outputs and the activation pipeline.
- De-skews diagonally arriving column data, then performs signed read-modify-write (accumulate or overwrite) into the selected buffer/row.
- Streams each updated row out and allows random read-back of any stored row.

---
 rtl/accumulator_bank_pkg.sv | 20 ++
 rtl/accumulator_skew.sv | 47 ++++
 rtl/accumulator_bank.sv | 127 ++++++++++++
 tb/tb_accumulator_bank.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/accumulator_bank_pkg.sv
// accumulator_bank_pkg: shared defaults, saturation bounds and the control word carried through the skew line.
package accumulator_bank_pkg;
   localparam int DEF_NUM_COLS = 4;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_DEPTH    = 16;
   // row_addr is carried at a fixed width; the top trims it back to ADDR_W
   localparam int MAX_ADDR_W   = 16;
   typedef struct packed {
      logic                  valid;
      logic                  acc_mode;
      logic                  buf_sel;
      logic [MAX_ADDR_W-1:0] row_addr;
   } acc_ctrl_t;
   function automatic logic [63:0] SAT_MAX(input int unsigned w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction
   function automatic logic [63:0] SAT_MIN(input int unsigned w);
      return ~SAT_MAX(w);
   endfunction
endpackage

// File: rtl/accumulator_skew.sv
// accumulator_skew: de-skews diagonal MMU columns (col c delayed NUM_COLS-1-c) and
// delays the control word NUM_COLS-1 cycles so data and control line up.
module accumulator_skew
   import accumulator_bank_pkg::*;
#(
   parameter int NUM_COLS = DEF_NUM_COLS,
   parameter int DATA_W   = DEF_DATA_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  acc_ctrl_t                  ctrl_i,
   input  logic [NUM_COLS*DATA_W-1:0] col_i,
   output acc_ctrl_t                  ctrl_o,
   output logic [NUM_COLS*DATA_W-1:0] col_o
);
   if (NUM_COLS == 1) begin : g_ctrl_pass
      assign ctrl_o = ctrl_i;
   end else begin : g_ctrl_pipe
      acc_ctrl_t ctrl_q [NUM_COLS-1];
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < NUM_COLS-1; i++) ctrl_q[i] <= '0;
         end else begin
            ctrl_q[0] <= ctrl_i;
            for (int i = 1; i < NUM_COLS-1; i++) ctrl_q[i] <= ctrl_q[i-1];
         end
      end
      assign ctrl_o = ctrl_q[NUM_COLS-2];
   end
   for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      localparam int D = NUM_COLS - 1 - c;
      if (D == 0) begin : g_pass
         assign col_o[c*DATA_W +: DATA_W] = col_i[c*DATA_W +: DATA_W];
      end else begin : g_pipe
         logic [DATA_W-1:0] pipe_q [D];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < D; i++) pipe_q[i] <= '0;
            end else begin
               pipe_q[0] <= col_i[c*DATA_W +: DATA_W];
               for (int i = 1; i < D; i++) pipe_q[i] <= pipe_q[i-1];
            end
         end
         assign col_o[c*DATA_W +: DATA_W] = pipe_q[D-1];
      end
   end
endmodule

// File: rtl/accumulator_bank.sv
// accumulator_bank: double-buffered NUM_COLS x DEPTH signed accumulator with skew alignment,
// row streaming, random read-back and single-cycle buffer clear. Define ACC_SATURATE_EN for saturating adds.
module accumulator_bank
   import accumulator_bank_pkg::*;
#(
   parameter int NUM_COLS = DEF_NUM_COLS,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int ADDR_W   = $clog2(DEPTH)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       valid_in,
   input  logic                       acc_mode,
   input  logic                       buf_sel,
   input  logic [ADDR_W-1:0]          row_addr,
   input  logic [NUM_COLS*DATA_W-1:0] col_in,
   input  logic                       clr_req,
   input  logic                       clr_buf,
   input  logic                       rd_en,
   input  logic                       rd_buf,
   input  logic [ADDR_W-1:0]          rd_addr,
   output logic                       valid_out,
   output logic [NUM_COLS*DATA_W-1:0] acc_out,
   output logic                       rd_valid,
   output logic [NUM_COLS*DATA_W-1:0] rd_data,
   output logic                       sat_flag
);
   localparam int ROW_W = NUM_COLS * DATA_W;
   acc_ctrl_t          ctrl_in, al_ctrl;
   logic [ROW_W-1:0]   al_col;
   logic [ROW_W-1:0]   mem_q [2][DEPTH];
   logic [DEPTH-1:0]   rv_q [2];
   logic [ADDR_W-1:0]  al_addr;
   logic               upd, clr_hit, acc_eff;
   logic [ROW_W-1:0]   stored_row, row_d;
   logic [DATA_W-1:0]  old_w, in_w;
   logic               valid_out_q, rd_valid_q;
   logic [ROW_W-1:0]   acc_out_q, rd_data_q;
   assign ctrl_in = '{valid: valid_in, acc_mode: acc_mode, buf_sel: buf_sel,
                      row_addr: MAX_ADDR_W'(row_addr)};
   accumulator_skew #(.NUM_COLS(NUM_COLS), .DATA_W(DATA_W)) u_skew (
      .clk    (clk),
      .rst    (rst),
      .ctrl_i (ctrl_in),
      .col_i  (col_in),
      .ctrl_o (al_ctrl),
      .col_o  (al_col)
   );
   assign al_addr    = al_ctrl.row_addr[ADDR_W-1:0];
   assign upd        = al_ctrl.valid && (al_ctrl.row_addr < MAX_ADDR_W'(DEPTH));
   // a coincident clear of the target buffer turns the update into an overwrite
   assign clr_hit    = clr_req && (clr_buf == al_ctrl.buf_sel);
   assign acc_eff    = al_ctrl.acc_mode && !clr_hit;
   assign stored_row = rv_q[al_ctrl.buf_sel][al_addr] ? mem_q[al_ctrl.buf_sel][al_addr] : '0;
`ifdef ACC_SATURATE_EN
   localparam logic [DATA_W-1:0] SAT_MAX_W = DATA_W'(SAT_MAX(DATA_W));
   localparam logic [DATA_W-1:0] SAT_MIN_W = DATA_W'(SAT_MIN(DATA_W));
   logic [DATA_W:0] sum_w;
   logic            ovf, sat_any, sat_q, sat_d;
   always_comb begin
      row_d   = '0;
      old_w   = '0;
      in_w    = '0;
      sum_w   = '0;
      ovf     = 1'b0;
      sat_any = 1'b0;
      for (int c = 0; c < NUM_COLS; c++) begin
         old_w = stored_row[c*DATA_W +: DATA_W];
         in_w  = al_col[c*DATA_W +: DATA_W];
         sum_w = {old_w[DATA_W-1], old_w} + {in_w[DATA_W-1], in_w};
         ovf   = acc_eff && (sum_w[DATA_W] != sum_w[DATA_W-1]);
         row_d[c*DATA_W +: DATA_W] = !acc_eff ? in_w :
                                     !ovf ? sum_w[DATA_W-1:0] :
                                     sum_w[DATA_W] ? SAT_MIN_W : SAT_MAX_W;
         sat_any = sat_any | ovf;
      end
   end
   assign sat_d = sat_q | (upd & sat_any);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sat_q <= 1'b0;
      else     sat_q <= sat_d;
   end
   assign sat_flag = sat_q;
`else
   always_comb begin
      row_d = '0;
      old_w = '0;
      in_w  = '0;
      for (int c = 0; c < NUM_COLS; c++) begin
         old_w = stored_row[c*DATA_W +: DATA_W];
         in_w  = al_col[c*DATA_W +: DATA_W];
         row_d[c*DATA_W +: DATA_W] = acc_eff ? old_w + in_w : in_w;
      end
   end
   assign sat_flag = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (upd) mem_q[al_ctrl.buf_sel][al_addr] <= row_d;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rv_q[0] <= '0;
         rv_q[1] <= '0;
      end else begin
         if (clr_req) rv_q[clr_buf] <= '0;
         if (upd)     rv_q[al_ctrl.buf_sel][al_addr] <= 1'b1;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_out_q <= 1'b0;
         acc_out_q   <= '0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         valid_out_q <= upd;
         rd_valid_q  <= rd_en;
         if (upd)   acc_out_q <= row_d;
         if (rd_en) rd_data_q <= rv_q[rd_buf][rd_addr] ? mem_q[rd_buf][rd_addr] : '0;
      end
   end
   assign valid_out = valid_out_q;
   assign acc_out   = acc_out_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
endmodule

// File: tb/tb_accumulator_bank.sv
// tb_accumulator_bank: scoreboard bench with a skew-generating driver and a behavioural storage model.
module tb_accumulator_bank;
   localparam int NC = 4, DW = 32, DEPTH = 16, AW = 4;
   localparam int RW = NC * DW;
   logic clk = 1'b0, rst = 1'b1;
   logic valid_in = 0, acc_mode = 0, buf_sel = 0, clr_req = 0, clr_buf = 0, rd_en = 0, rd_buf = 0;
   logic [AW-1:0] row_addr = '0, rd_addr = '0;
   logic [RW-1:0] col_in = '0;
   logic valid_out, rd_valid, sat_flag;
   logic [RW-1:0] acc_out, rd_data;
   int checks = 0, failures = 0;
   logic [RW-1:0] hist [NC];
   logic [RW-1:0] exp_q [$];
   logic [RW-1:0] m_mem [2][DEPTH];
   logic          m_rv [2][DEPTH];
   logic          m_sat = 1'b0;

   accumulator_bank #(.NUM_COLS(NC), .DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .acc_mode(acc_mode), .buf_sel(buf_sel),
      .row_addr(row_addr), .col_in(col_in), .clr_req(clr_req), .clr_buf(clr_buf),
      .rd_en(rd_en), .rd_buf(rd_buf), .rd_addr(rd_addr), .valid_out(valid_out),
      .acc_out(acc_out), .rd_valid(rd_valid), .rd_data(rd_data), .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   function automatic logic [RW-1:0] row4(input int a, input int b, input int c, input int d);
      return {DW'(d), DW'(c), DW'(b), DW'(a)};
   endfunction

   function automatic logic [RW-1:0] model_rd(input logic b, input logic [AW-1:0] r);
      return m_rv[b][r] ? m_mem[b][r] : '0;
   endfunction

   task automatic model_reset();
      for (int b = 0; b < 2; b++) for (int i = 0; i < DEPTH; i++) m_rv[b][i] = 1'b0;
      m_sat = 1'b0;
      exp_q.delete();
      for (int k = 0; k < NC; k++) hist[k] = '0;
   endtask

   task automatic model_upd(input logic mode, input logic b, input logic [AW-1:0] r,
                            input logic [RW-1:0] vals, input logic coinc_clr);
      logic [RW-1:0] old, nw;
      longint s;
      if (coinc_clr) begin
         for (int i = 0; i < DEPTH; i++) m_rv[b][i] = 1'b0;
         mode = 1'b0;
      end
      old = model_rd(b, r);
      for (int c = 0; c < NC; c++) begin
         s = longint'($signed(old[c*DW +: DW])) + longint'($signed(vals[c*DW +: DW]));
`ifdef ACC_SATURATE_EN
         if (mode && s > 64'sd2147483647) begin s = 64'sd2147483647; m_sat = 1'b1; end
         if (mode && s < -64'sd2147483648) begin s = -64'sd2147483648; m_sat = 1'b1; end
`endif
         nw[c*DW +: DW] = mode ? s[DW-1:0] : vals[c*DW +: DW];
      end
      m_mem[b][r] = nw;
      m_rv[b][r]  = 1'b1;
      exp_q.push_back(nw);
   endtask

   // one clock: drive the logical row on column 0 and older rows on later columns, then score valid_out
   task automatic step(input logic v, input logic mode, input logic b, input logic [AW-1:0] r,
                       input logic [RW-1:0] vals);
      logic [RW-1:0] e;
      for (int k = NC-1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = v ? vals : '0;
      for (int c = 0; c < NC; c++) col_in[c*DW +: DW] = hist[c][c*DW +: DW];
      valid_in = v; acc_mode = mode; buf_sel = b; row_addr = r;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      if (valid_out) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_valid_out: acc_out=%h with nothing outstanding", acc_out);
         end else begin
            e = exp_q.pop_front();
            if (acc_out !== e) begin
               failures++;
               $display("FAIL acc_out: got %h expected %h", acc_out, e);
            end
         end
      end
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic issue(input logic mode, input logic b, input logic [AW-1:0] r,
                        input logic [RW-1:0] vals, input logic coinc_clr);
      model_upd(mode, b, r, vals, coinc_clr);
      step(1'b1, mode, b, r, vals);
   endtask

   task automatic drain(output int n);
      n = 0;
      while (exp_q.size() != 0 && n < 10) begin
         idle();
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout: %0d rows still outstanding after %0d cycles", exp_q.size(), n);
         exp_q.delete();
      end
   endtask

   task automatic do_read(input logic b, input logic [AW-1:0] r, input string name);
      logic [RW-1:0] e;
      e = model_rd(b, r);
      rd_en = 1'b1; rd_buf = b; rd_addr = r;
      idle();
      rd_en = 1'b0;
      checks++;
      if ({rd_valid, rd_data} !== {1'b1, e}) begin
         failures++;
         $display("FAIL %s: rd_valid=%b rd_data=%h expected rd_valid=1 rd_data=%h", name, rd_valid, rd_data, e);
      end
   endtask

   task automatic test_reset();
      model_reset();
      rst = 1'b1;
      repeat (2) idle();
      checks++;
      if ({valid_out, rd_valid, sat_flag} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags: valid_out=%b rd_valid=%b sat_flag=%b expected 000", valid_out, rd_valid, sat_flag);
      end
      checks++;
      if ({acc_out, rd_data} !== '0) begin
         failures++;
         $display("FAIL reset_data: acc_out=%h rd_data=%h expected 0", acc_out, rd_data);
      end
      rst = 1'b0;
      idle();
   endtask

   task automatic test_overwrite();
      int n;
      issue(1'b0, 1'b0, 4'd3, row4(1, 2, 3, 4), 1'b0);
      drain(n);
      checks++;
      if (n != NC - 1) begin
         failures++;
         $display("FAIL latency: valid_out %0d cycles after valid_in, expected %0d", n + 1, NC);
      end
      do_read(1'b0, 4'd3, "read_b0r3_overwrite");
   endtask

   task automatic test_back_to_back();
      int n;
      issue(1'b1, 1'b0, 4'd3, row4(10, 10, 10, 10), 1'b0);
      issue(1'b1, 1'b0, 4'd3, row4(10, 10, 10, 10), 1'b0);
      drain(n);
      do_read(1'b0, 4'd3, "read_b0r3_accum");
      checks++;
      if (model_rd(1'b0, 4'd3) !== row4(21, 22, 23, 24)) begin
         failures++;
         $display("FAIL model_b2b: model row %h expected %h", model_rd(1'b0, 4'd3), row4(21, 22, 23, 24));
      end
   endtask

   task automatic test_buffers();
      int n;
      issue(1'b0, 1'b1, 4'd3, row4(7, 7, 7, 7), 1'b0);
      drain(n);
      do_read(1'b0, 4'd3, "read_b0r3_isolated");
      do_read(1'b1, 4'd3, "read_b1r3");
   endtask

   task automatic test_clear();
      int n;
      logic [RW-1:0] pre;
      issue(1'b0, 1'b0, 4'd5, row4(100, 100, 100, 100), 1'b0);
      drain(n);
      pre = model_rd(1'b0, 4'd3);
      issue(1'b1, 1'b0, 4'd5, row4(2, 2, 2, 2), 1'b1);
      idle();
      idle();
      clr_req = 1'b1; clr_buf = 1'b0;
      rd_en = 1'b1; rd_buf = 1'b0; rd_addr = 4'd3;
      idle();
      clr_req = 1'b0; rd_en = 1'b0;
      checks++;
      if ({rd_valid, rd_data} !== {1'b1, pre}) begin
         failures++;
         $display("FAIL read_during_clear: rd_valid=%b rd_data=%h expected 1 %h", rd_valid, rd_data, pre);
      end
      drain(n);
      do_read(1'b0, 4'd5, "read_b0r5_after_clear");
      do_read(1'b0, 4'd3, "read_b0r3_cleared");
      do_read(1'b1, 4'd3, "read_b1r3_untouched");
   endtask

   task automatic test_saturate();
      int n;
      logic [RW-1:0] want;
`ifdef ACC_SATURATE_EN
      want = {NC{32'h7FFF_FFFF}};
`else
      want = {NC{32'h8000_0010}};
`endif
      issue(1'b0, 1'b0, 4'd7, {NC{32'h7FFF_FFF0}}, 1'b0);
      issue(1'b1, 1'b0, 4'd7, {NC{32'h0000_0020}}, 1'b0);
      drain(n);
      do_read(1'b0, 4'd7, "read_sat_row");
      checks++;
      if (model_rd(1'b0, 4'd7) !== want || sat_flag !== m_sat) begin
         failures++;
         $display("FAIL saturate: sat_flag=%b row=%h expected sat_flag=%b row=%h", sat_flag, model_rd(1'b0, 4'd7), m_sat, want);
      end
   endtask

   task automatic test_reset_midstream();
      int seen = 0;
      issue(1'b0, 1'b0, 4'd3, row4(5, 6, 7, 8), 1'b0);
      issue(1'b0, 1'b1, 4'd2, row4(9, 9, 9, 9), 1'b0);
      idle();
      rst = 1'b1;
      model_reset();
      idle();
      checks++;
      if ({valid_out, rd_valid, sat_flag, acc_out, rd_data} !== '0) begin
         failures++;
         $display("FAIL reset_midstream_outputs: valid_out=%b rd_valid=%b sat_flag=%b acc_out=%h rd_data=%h expected 0",
                  valid_out, rd_valid, sat_flag, acc_out, rd_data);
      end
      rst = 1'b0;
      for (int i = 0; i < 2 * NC; i++) begin
         idle();
         if (valid_out) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL reset_discard: %0d valid_out pulses after reset, expected 0", seen);
      end
      do_read(1'b0, 4'd3, "read_b0r3_after_rst");
      do_read(1'b1, 4'd2, "read_b1r2_after_rst");
   endtask

   initial begin
      test_reset();
      test_overwrite();
      test_back_to_back();
      test_buffers();
      test_clear();
      test_saturate();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
